// File: rtl/tick_divider.sv
// tick_divider: clock-enable tick generator dividing clk_in by a run-time
// programmable ratio, with a cascaded sub_tick every SUB_DIV ticks and a
// pulse/square clk_out. The ratio can be reloaded while running; a reload
// takes effect at the end of the current period.
//
// Ports
//   clk_in      system clock, all logic on posedge
//   rst         asynchronous, active-low reset
//   en          count enable; 0 freezes count, sub counter and clk_out
//   sync_clr    synchronous restart of count/sub counter (ratio kept)
//   mode        0: clk_out is the tick pulse, 1: clk_out toggles per tick
//   div_load    1-cycle strobe requesting ratio div_value
//   div_value   requested ratio, must be >= 2
//   div_pending accepted ratio waiting for the terminal count
//   div_err     1-cycle pulse: div_load with div_value < 2 rejected
//   tick        1-cycle pulse every div_reg enabled cycles
//   sub_tick    1-cycle pulse with every SUB_DIV-th tick
//   clk_out     pulse or square output per mode
module tick_divider #(
  parameter int unsigned WIDTH       = 26,
  parameter int unsigned DIV_DEFAULT = 50000000,
  parameter int unsigned SUB_DIV     = 60
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             mode,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             div_pending,
  output logic             div_err,
  output logic             tick,
  output logic             sub_tick,
  output logic             clk_out
);

  localparam int unsigned      SUB_W    = $clog2(SUB_DIV);
  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DIV_DEFAULT);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] shadow;
  logic [SUB_W-1:0] sub_cnt;

  logic [WIDTH-1:0] div_last_c;
  logic             term_c;
  logic             load_ok_c;
  logic             load_bad_c;
  logic             sub_wrap_c;

  // Terminal-count and load qualification
  always_comb begin
    div_last_c = div_reg - WIDTH'(1);
    term_c     = en & (count == div_last_c);
    load_ok_c  = div_load & (div_value >= WIDTH'(2));
    load_bad_c = div_load & (div_value <  WIDTH'(2));
    sub_wrap_c = (sub_cnt == SUB_LAST);
  end

  // Counters, ratio reload and registered outputs; sync_clr beats term beats counting
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      sub_cnt     <= '0;
      div_reg     <= DIV_RST;
      shadow      <= '0;
      div_pending <= 1'b0;
      div_err     <= 1'b0;
      tick        <= 1'b0;
      sub_tick    <= 1'b0;
      clk_out     <= 1'b0;
    end else begin
      div_err <= load_bad_c;
      if (sync_clr) begin
        count    <= '0;
        sub_cnt  <= '0;
        tick     <= 1'b0;
        sub_tick <= 1'b0;
        clk_out  <= 1'b0;
        if (load_ok_c) begin
          shadow      <= div_value;
          div_pending <= 1'b1;
        end
      end else if (term_c) begin
        count    <= '0;
        tick     <= 1'b1;
        sub_tick <= sub_wrap_c;
        sub_cnt  <= sub_wrap_c ? '0 : sub_cnt + SUB_W'(1);
        clk_out  <= mode ? ~clk_out : 1'b1;
        // A load landing on the terminal edge wins over an older pending value
        if (load_ok_c) begin
          div_reg     <= div_value;
          shadow      <= div_value;
          div_pending <= 1'b0;
        end else if (div_pending) begin
          div_reg     <= shadow;
          div_pending <= 1'b0;
        end
      end else begin
        tick     <= 1'b0;
        sub_tick <= 1'b0;
        if (en) begin
          count <= count + WIDTH'(1);
          if (!mode) clk_out <= 1'b0;
        end
        if (load_ok_c) begin
          shadow      <= div_value;
          div_pending <= 1'b1;
        end
      end
    end
  end

endmodule
